// File: rtl/cpu_pkg.sv
// Shared load/store funct3 codes, MMIO register offsets and STATUS layout.
// Pure definitions; no logic, no latency, no flow control.
package cpu_pkg;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    localparam logic [2:0] STORE_SB = 3'b000;
    localparam logic [2:0] STORE_SH = 3'b001;
    localparam logic [2:0] STORE_SW = 3'b010;

    localparam logic [4:0] MMIO_OFF_TXDATA  = 5'h00;
    localparam logic [4:0] MMIO_OFF_STATUS  = 5'h04;
    localparam logic [4:0] MMIO_OFF_CTRL    = 5'h08;
    localparam logic [4:0] MMIO_OFF_TIMER   = 5'h0C;
    localparam logic [4:0] MMIO_OFF_TIMECMP = 5'h10;
    localparam logic [4:0] MMIO_OFF_IRQCLR  = 5'h14;

    localparam int STATUS_FULL_BIT  = 0;
    localparam int STATUS_EMPTY_BIT = 1;
    localparam int STATUS_COUNT_LSB = 2;
    localparam int STATUS_IRQ_BIT   = 8;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO; head is combinational (0 when empty), count/flags registered.
// Push ignored when full, pop ignored when empty; caller applies backpressure from full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO window on the data-memory port: TX byte FIFO, STATUS/CTRL, timer with compare IRQ.
// Loads zero-latency, stores commit at the edge; mem_busy holds a TXDATA store while the FIFO is full.
module mmio_responder
    import cpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_en,
    input  logic        mem_write_en,
    input  logic [2:0]  load_type,
    input  logic [2:0]  store_type,
    input  logic [31:0] ram_address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mem_busy,
    output logic        access_err,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        timer_irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit, is_store, is_load, st_ok, ld_ok, st_mis, ld_mis, wr_ok, rd_ok;
    logic [4:0]    word_off;
    logic [3:0]    be;
    logic [31:0]   wdata, rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic          push_req, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;

    logic [1:0]    ctrl_q, ctrl_d;
    logic [31:0]   timer_q, timer_d;
    logic [31:0]   timecmp_q, timecmp_d;
    logic          irq_q, irq_d;

    assign hit      = (ram_address[31:5] == BASE_ADDR[31:5]);
    assign word_off = {ram_address[4:2], 2'b00};
    // A simultaneous read and write is handled purely as a store.
    assign is_store = mem_write_en;
    assign is_load  = mem_read_en && !mem_write_en;

    always_comb begin
        st_ok  = (store_type == STORE_SB) || (store_type == STORE_SH) || (store_type == STORE_SW);
        ld_ok  = (load_type == LOAD_LB) || (load_type == LOAD_LH) || (load_type == LOAD_LW) ||
                 (load_type == LOAD_LBU) || (load_type == LOAD_LHU);
        st_mis = ((store_type == STORE_SH) && ram_address[0]) ||
                 ((store_type == STORE_SW) && (ram_address[1:0] != 2'b00));
        ld_mis = (((load_type == LOAD_LH) || (load_type == LOAD_LHU)) && ram_address[0]) ||
                 ((load_type == LOAD_LW) && (ram_address[1:0] != 2'b00));
        wr_ok      = hit && is_store && st_ok && !st_mis;
        rd_ok      = hit && is_load && ld_ok && !ld_mis;
        access_err = hit && ((is_store && !(st_ok && !st_mis)) || (is_load && !(ld_ok && !ld_mis)));
    end

    always_comb begin
        be    = 4'b0000;
        wdata = data_in;
        case (store_type)
            STORE_SB: begin be = 4'b0001 << ram_address[1:0]; wdata = {4{data_in[7:0]}}; end
            STORE_SH: begin be = ram_address[1] ? 4'b1100 : 4'b0011; wdata = {2{data_in[15:0]}}; end
            STORE_SW: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
    end

    // Only stores that land a byte in lane 0 feed the FIFO, so only those can stall.
    assign push_req  = wr_ok && (word_off == MMIO_OFF_TXDATA) && be[0];
    assign mem_busy  = push_req && fifo_full;
    assign fifo_push = push_req && !fifo_full;
    assign fifo_pop  = !fifo_empty && tx_ready;
    assign tx_valid  = !fifo_empty;
    assign tx_data   = fifo_head;
    assign timer_irq = irq_q && ctrl_q[1];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (data_in[7:0]),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    always_comb begin
        ctrl_d    = ctrl_q;
        timer_d   = timer_q + {31'd0, ctrl_q[0]};
        timecmp_d = timecmp_q;
        irq_d     = irq_q;
        if (wr_ok && (word_off == MMIO_OFF_CTRL) && be[0])
            ctrl_d = wdata[1:0];
        if (wr_ok && (word_off == MMIO_OFF_TIMER))
            timer_d = merge_bytes(timer_q, wdata, be);
        if (wr_ok && (word_off == MMIO_OFF_TIMECMP))
            timecmp_d = merge_bytes(timecmp_q, wdata, be);
        if (wr_ok && (word_off == MMIO_OFF_IRQCLR) && be[0] && wdata[0])
            irq_d = 1'b0;
        // Compare uses the pre-increment count; a match overrides a same-cycle clear.
        if (ctrl_q[0] && (timer_q == timecmp_q))
            irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q    <= 2'b00;
            timer_q   <= 32'd0;
            timecmp_q <= 32'hFFFF_FFFF;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            timer_q   <= timer_d;
            timecmp_q <= timecmp_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rword = 32'd0;
        case (word_off)
            MMIO_OFF_STATUS: begin
                rword[STATUS_FULL_BIT]          = fifo_full;
                rword[STATUS_EMPTY_BIT]         = fifo_empty;
                rword[STATUS_COUNT_LSB +: 5]    = 5'(fifo_count);
                rword[STATUS_IRQ_BIT]           = irq_q;
            end
            MMIO_OFF_CTRL:    rword = {30'd0, ctrl_q};
            MMIO_OFF_TIMER:   rword = timer_q;
            MMIO_OFF_TIMECMP: rword = timecmp_q;
            default:          rword = 32'd0;
        endcase
        case (ram_address[1:0])
            2'd0:    rbyte = rword[7:0];
            2'd1:    rbyte = rword[15:8];
            2'd2:    rbyte = rword[23:16];
            default: rbyte = rword[31:24];
        endcase
        rhalf    = ram_address[1] ? rword[31:16] : rword[15:0];
        data_out = 32'd0;
        if (rd_ok) begin
            case (load_type)
                LOAD_LB:  data_out = {{24{rbyte[7]}}, rbyte};
                LOAD_LBU: data_out = {24'd0, rbyte};
                LOAD_LH:  data_out = {{16{rhalf[15]}}, rhalf};
                LOAD_LHU: data_out = {16'd0, rhalf};
                default:  data_out = rword;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: FIFO push/backpressure, load extension, timer IRQ, errors, reset.
module tb_mmio_responder;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk, reset, mem_read_en, mem_write_en, tx_ready;
    logic [2:0]  load_type, store_type;
    logic [31:0] ram_address, data_in, data_out;
    logic        mem_busy, access_err, tx_valid, timer_irq;
    logic [7:0]  tx_data;
    logic [31:0] rd;
    logic        last_err;
    int          total, bad;

    mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .load_type(load_type), .store_type(store_type), .ram_address(ram_address),
        .data_in(data_in), .data_out(data_out), .mem_busy(mem_busy), .access_err(access_err),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .timer_irq(timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All ops start at a negedge and occupy exactly one cycle.
    task automatic st(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        mem_write_en = 1'b1; store_type = t; ram_address = a; data_in = d;
        #1 last_err = access_err;
        @(negedge clk);
        mem_write_en = 1'b0;
    endtask

    task automatic ld(input logic [2:0] t, input logic [31:0] a, output logic [31:0] v);
        mem_read_en = 1'b1; load_type = t; ram_address = a;
        #1 v = data_out; last_err = access_err;
        @(negedge clk);
        mem_read_en = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [8];
        logic       found;
        total = 0; bad = 0;
        reset = 1'b1; mem_read_en = 1'b0; mem_write_en = 1'b0; tx_ready = 1'b0;
        load_type = 3'b010; store_type = 3'b010; ram_address = 32'd0; data_in = 32'd0;
        last_err = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_irq", 32'(timer_irq), 32'd0);
        check_eq("rst_busy", 32'(mem_busy), 32'd0);
        @(negedge clk);
        ld(3'b010, BASE + 32'h10, rd); check_eq("rst_timecmp", rd, 32'hFFFF_FFFF);
        ld(3'b010, BASE + 32'h04, rd); check_eq("rst_status", rd, 32'h0000_0002);

        // 1: single push
        st(3'b010, BASE, 32'h1234_5641);
        #1 check_eq("t1_tx_valid", 32'(tx_valid), 32'd1);
        check_eq("t1_tx_data", 32'(tx_data), 32'h41);
        @(negedge clk);
        ld(3'b010, BASE + 32'h04, rd); check_eq("t1_status", rd, 32'h0000_0004);

        // 2: fill, stall, release with one pop
        for (int i = 1; i < 8; i++) st(3'b000, BASE, 32'(i));
        ld(3'b010, BASE + 32'h04, rd); check_eq("t2_status_full", rd, 32'h0000_0021);
        mem_write_en = 1'b1; store_type = 3'b000; ram_address = BASE; data_in = 32'h99;
        #1 check_eq("t2_busy0", 32'(mem_busy), 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1 check_eq("t2_busy_held", 32'(mem_busy), 32'd1);
        end
        tx_ready = 1'b1;
        #1 check_eq("t2_busy_pop_cycle", 32'(mem_busy), 32'd1);
        @(negedge clk);
        tx_ready = 1'b0;
        #1 check_eq("t2_busy_dropped", 32'(mem_busy), 32'd0);
        @(negedge clk);
        mem_write_en = 1'b0;
        ld(3'b010, BASE + 32'h04, rd); check_eq("t2_status_after", rd, 32'h0000_0021);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h99};
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 check_eq($sformatf("t2_drain%0d", i), 32'(tx_data), 32'(exp_q[i]));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        #1 check_eq("t2_empty", 32'(tx_valid), 32'd0);
        @(negedge clk);

        // 3: load extension on TIMECMP
        st(3'b010, BASE + 32'h10, 32'h8000_80F0);
        ld(3'b000, BASE + 32'h10, rd); check_eq("t3_lb", rd, 32'hFFFF_FFF0);
        ld(3'b100, BASE + 32'h10, rd); check_eq("t3_lbu", rd, 32'h0000_00F0);
        ld(3'b001, BASE + 32'h12, rd); check_eq("t3_lh", rd, 32'hFFFF_8000);
        ld(3'b101, BASE + 32'h12, rd); check_eq("t3_lhu", rd, 32'h0000_8000);
        st(3'b000, BASE + 32'h11, 32'h0000_00AB);
        ld(3'b010, BASE + 32'h10, rd); check_eq("t3_sb_merge", rd, 32'h8000_ABF0);

        // 4: timer compare interrupt
        st(3'b010, BASE + 32'h0C, 32'd5);
        st(3'b010, BASE + 32'h10, 32'd8);
        st(3'b010, BASE + 32'h08, 32'd3);
        mem_read_en = 1'b1; load_type = 3'b010; ram_address = BASE + 32'h0C;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #1;
            if (data_out == 32'd8) begin
                found = 1'b1;
                check_eq("t4_irq_before", 32'(timer_irq), 32'd0);
            end
            @(negedge clk);
        end
        check_eq("t4_timer_reach8", 32'(found), 32'd1);
        #1 check_eq("t4_irq_rise", 32'(timer_irq), 32'd1);
        mem_read_en = 1'b0;
        st(3'b010, BASE + 32'h14, 32'd1);
        #1 check_eq("t4_irq_clr", 32'(timer_irq), 32'd0);
        st(3'b010, BASE + 32'h0C, 32'd8);
        st(3'b010, BASE + 32'h14, 32'd1);
        #1 check_eq("t4_set_wins", 32'(timer_irq), 32'd1);
        st(3'b010, BASE + 32'h0C, 32'h100);
        ld(3'b010, BASE + 32'h0C, rd); check_eq("t4_write_wins", rd, 32'h100);

        // 5: errors and out-of-window
        ld(3'b010, BASE + 32'h06, rd);
        check_eq("t5_lw_mis_err", 32'(last_err), 32'd1);
        check_eq("t5_lw_mis_data", rd, 32'd0);
        st(3'b001, BASE + 32'h09, 32'h0);
        check_eq("t5_sh_mis_err", 32'(last_err), 32'd1);
        ld(3'b010, BASE + 32'h08, rd); check_eq("t5_ctrl_kept", rd, 32'd3);
        ld(3'b010, BASE + 32'h04, rd); check_eq("t5_status_kept", rd, 32'h0000_0102);
        ld(3'b011, BASE + 32'h04, rd); check_eq("t5_bad_type_err", 32'(last_err), 32'd1);
        ld(3'b010, 32'h2000_0000, rd);
        check_eq("t5_oow_data", rd, 32'd0);
        check_eq("t5_oow_err", 32'(last_err), 32'd0);

        // 6: reset while stalled on a full FIFO with the timer running
        for (int i = 0; i < 8; i++) st(3'b000, BASE, 32'(8'hA0 + i));
        mem_write_en = 1'b1; store_type = 3'b000; ram_address = BASE; data_in = 32'hEE;
        #1 check_eq("t6_busy_before", 32'(mem_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        #1 check_eq("t6_busy", 32'(mem_busy), 32'd0);
        check_eq("t6_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("t6_irq", 32'(timer_irq), 32'd0);
        mem_write_en = 1'b0; reset = 1'b0;
        ld(3'b010, BASE + 32'h0C, rd); check_eq("t6_timer", rd, 32'd0);
        ld(3'b010, BASE + 32'h10, rd); check_eq("t6_timecmp", rd, 32'hFFFF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
